// File: rtl/tap_dmi_reg.sv
// JTAG DMI data register: shifts in {addr, data, op}, issues the debug-module
// request on Update-DR and reports read data plus sticky status on Capture-DR.
module tap_dmi_reg #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_tck,
  input  logic                  i_reset,
  input  logic                  i_capture,
  input  logic                  i_shift,
  input  logic                  i_update,
  input  logic                  i_tdi,
  output logic                  o_tdo,
  input  logic                  i_dmireset,
  output logic                  o_req_valid,
  input  logic                  i_req_ready,
  output logic [1:0]            o_req_op,
  output logic [ADDR_WIDTH-1:0] o_req_addr,
  output logic [DATA_WIDTH-1:0] o_req_data,
  input  logic                  i_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  i_rsp_error,
  output logic                  o_busy,
  output logic [1:0]            o_status
);

  localparam int W = ADDR_WIDTH + DATA_WIDTH + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic [1:0]            state;
  logic [W-1:0]          shreg;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  sticky_busy;
  logic                  sticky_fail;

  logic [1:0]            sh_op;
  logic [DATA_WIDTH-1:0] sh_data;
  logic [ADDR_WIDTH-1:0] sh_addr;
  logic                  idle;
  logic                  upd;
  logic                  accept;
  logic                  set_busy;
  logic                  set_fail;
  logic [1:0]            cap_status;

  assign sh_op   = shreg[1:0];
  assign sh_data = shreg[DATA_WIDTH+1:2];
  assign sh_addr = shreg[W-1:DATA_WIDTH+2];

  assign idle = (state == IDLE);
  assign upd  = i_update & ~i_capture & ~i_shift;

  assign accept = upd & idle & (o_status == 2'd0) &
                  ((sh_op == OP_READ) | (sh_op == OP_WRITE));

  // Touching the register while a transaction is in flight poisons status.
  assign set_busy = ~idle & (i_capture | upd);
  assign set_fail = (state == WAIT) & i_rsp_valid & i_rsp_error;

  assign o_status   = sticky_busy ? 2'd3 : (sticky_fail ? 2'd2 : 2'd0);
  assign cap_status = (sticky_busy | ~idle) ? 2'd3 : o_status;

  assign o_busy      = ~idle;
  assign o_req_valid = (state == REQ);

  always_ff @(posedge i_tck) begin
    if (i_reset) begin
      shreg <= '0;
    end else if (i_capture) begin
      shreg <= {last_addr, rdata, cap_status};
    end else if (i_shift) begin
      shreg <= {i_tdi, shreg[W-1:1]};
    end
  end

  always_ff @(negedge i_tck) begin
    if (i_reset) begin
      o_tdo <= 1'b0;
    end else begin
      o_tdo <= shreg[0];
    end
  end

  // A same-cycle set survives dmireset.
  always_ff @(posedge i_tck) begin
    if (i_reset) begin
      sticky_busy <= 1'b0;
      sticky_fail <= 1'b0;
    end else if (i_dmireset) begin
      sticky_busy <= set_busy;
      sticky_fail <= set_fail;
    end else begin
      if (set_busy) sticky_busy <= 1'b1;
      if (set_fail) sticky_fail <= 1'b1;
    end
  end

  always_ff @(posedge i_tck) begin
    if (i_reset) begin
      state      <= IDLE;
      o_req_op   <= '0;
      o_req_addr <= '0;
      o_req_data <= '0;
      last_addr  <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_req_op   <= sh_op;
            o_req_addr <= sh_addr;
            o_req_data <= sh_data;
            last_addr  <= sh_addr;
            state      <= REQ;
          end
        end
        REQ: begin
          if (i_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (i_rsp_valid) begin
            if (o_req_op == OP_READ) rdata <= i_rsp_data;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
